// File: rtl/eu_pkg.sv
// eu_pkg: shared types and constants for the execution-unit sequencer.
//   - FSM state enum (IDLE/EXEC/RESP)
//   - datapath widths and register-file geometry
//   - instruction field bit positions
//   - op-class constants and a small class-decode helper
package eu_pkg;

    localparam int unsigned BUS_WIDTH = 16;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned REG_AW    = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned INSTR_W   = 16;

    // Instruction layout: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned RD_MSB   = 11;
    localparam int unsigned RD_LSB   = 9;
    localparam int unsigned RA_MSB   = 8;
    localparam int unsigned RA_LSB   = 6;
    localparam int unsigned RB_MSB   = 5;
    localparam int unsigned RB_LSB   = 3;
    localparam int unsigned RSVD_MSB = 2;

    // Op classes: arithmetic is any op with op[3]==0; logic/shift by op[3:2]
    localparam logic       CLASS_ARITH_MSB = 1'b0;
    localparam logic [1:0] CLASS_LOGIC     = 2'b10;
    localparam logic [1:0] CLASS_SHIFT     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Only arithmetic ops update the zero flag
    function automatic logic op_is_arith(input logic [OP_W-1:0] op);
        return op[OP_W-1] == CLASS_ARITH_MSB;
    endfunction

endpackage

// File: rtl/eu_sequencer_if.sv
// eu_sequencer_if: instruction, register-load, EU and result signals of the sequencer.
//   master : sequencer side (drives instr_ready, EU operands, result stream, z_flag)
//   slave  : environment side (fetch/control, EU, result consumer)
interface eu_sequencer_if;
    import eu_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic                 ld_en;
    logic [REG_AW-1:0]    ld_addr;
    logic [BUS_WIDTH-1:0] ld_data;
    logic [OP_W-1:0]      eu_op_select;
    logic [BUS_WIDTH-1:0] eu_a;
    logic [BUS_WIDTH-1:0] eu_b;
    logic [BUS_WIDTH-1:0] eu_data_in;
    logic                 eu_zero;
    logic                 res_valid;
    logic                 res_ready;
    logic [BUS_WIDTH-1:0] res_data;
    logic [REG_AW-1:0]    res_rd;
    logic                 z_flag;

    modport master (
        input  instr_valid, instr, ld_en, ld_addr, ld_data,
               eu_data_in, eu_zero, res_ready,
        output instr_ready, eu_op_select, eu_a, eu_b,
               res_valid, res_data, res_rd, z_flag
    );

    modport slave (
        output instr_valid, instr, ld_en, ld_addr, ld_data,
               eu_data_in, eu_zero, res_ready,
        input  instr_ready, eu_op_select, eu_a, eu_b,
               res_valid, res_data, res_rd, z_flag
    );

endinterface

// File: rtl/eu_seq_regfile.sv
// eu_seq_regfile: NUM_REGS x BUS_WIDTH register file.
//   clk, rst          : clock, async active-high clear of all entries
//   we/waddr/wdata    : single write port
//   raddr_a/rdata_a   : combinational read port A
//   raddr_b/rdata_b   : combinational read port B
module eu_seq_regfile
    import eu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_AW-1:0]    waddr,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic [REG_AW-1:0]    raddr_a,
    output logic [BUS_WIDTH-1:0] rdata_a,
    input  logic [REG_AW-1:0]    raddr_b,
    output logic [BUS_WIDTH-1:0] rdata_b
);

    logic [BUS_WIDTH-1:0] regs_q [NUM_REGS];
    logic [BUS_WIDTH-1:0] regs_d [NUM_REGS];

    // Next-state: hold all entries, overwrite the addressed one on write
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/eu_sequencer.sv
// eu_sequencer: initiator side of the EU micro-operation interface.
//   clk, rst : clock, async active-high reset
//   bus      : eu_sequencer_if.master
//              instr_valid/instr_ready/instr : instruction handshake
//              ld_en/ld_addr/ld_data         : single-cycle register load (IDLE only)
//              eu_op_select/eu_a/eu_b        : registered EU inputs
//              eu_data_in/eu_zero            : combinational EU result
//              res_valid/res_ready/res_data/res_rd : result stream
//              z_flag                        : sticky zero flag (arithmetic ops only)
module eu_sequencer
    import eu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    eu_sequencer_if.master bus
);

    state_e               state_q,     state_d;
    logic [OP_W-1:0]      op_q,        op_d;
    logic [BUS_WIDTH-1:0] a_q,         a_d;
    logic [BUS_WIDTH-1:0] b_q,         b_d;
    logic [REG_AW-1:0]    rd_q,        rd_d;
    logic [BUS_WIDTH-1:0] res_data_q,  res_data_d;
    logic [REG_AW-1:0]    res_rd_q,    res_rd_d;
    logic                 res_valid_q, res_valid_d;
    logic                 z_q,         z_d;

    logic                 instr_ready_c;
    logic                 rf_we_c;
    logic [REG_AW-1:0]    rf_waddr_c;
    logic [BUS_WIDTH-1:0] rf_wdata_c;
    logic [BUS_WIDTH-1:0] rf_rdata_a;
    logic [BUS_WIDTH-1:0] rf_rdata_b;

    logic [OP_W-1:0]      instr_op;
    logic [REG_AW-1:0]    instr_rd;
    logic [REG_AW-1:0]    instr_ra;
    logic [REG_AW-1:0]    instr_rb;
    logic                 unused_rsvd;

    assign instr_op    = bus.instr[OP_MSB:OP_LSB];
    assign instr_rd    = bus.instr[RD_MSB:RD_LSB];
    assign instr_ra    = bus.instr[RA_MSB:RA_LSB];
    assign instr_rb    = bus.instr[RB_MSB:RB_LSB];
    assign unused_rsvd = ^bus.instr[RSVD_MSB:0];

    // Write port is shared: loads only in IDLE, writeback only in EXEC
    eu_seq_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we_c),
        .waddr   (rf_waddr_c),
        .wdata   (rf_wdata_c),
        .raddr_a (instr_ra),
        .rdata_a (rf_rdata_a),
        .raddr_b (instr_rb),
        .rdata_b (rf_rdata_b)
    );

    // Next-state and datapath control
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        rd_d          = rd_q;
        res_data_d    = res_data_q;
        res_rd_d      = res_rd_q;
        res_valid_d   = res_valid_q;
        z_d           = z_q;
        instr_ready_c = 1'b0;
        rf_we_c       = 1'b0;
        rf_waddr_c    = bus.ld_addr;
        rf_wdata_c    = bus.ld_data;

        unique case (state_q)
            IDLE: begin
                // A load takes priority; the instruction stays pending
                instr_ready_c = !bus.ld_en;
                if (bus.ld_en) begin
                    rf_we_c = 1'b1;
                end else if (bus.instr_valid) begin
                    op_d    = instr_op;
                    a_d     = rf_rdata_a;
                    b_d     = rf_rdata_b;
                    rd_d    = instr_rd;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rf_we_c     = 1'b1;
                rf_waddr_c  = rd_q;
                rf_wdata_c  = bus.eu_data_in;
                res_data_d  = bus.eu_data_in;
                res_rd_d    = rd_q;
                res_valid_d = 1'b1;
                if (op_is_arith(op_q)) begin
                    z_d = bus.eu_zero;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_valid_q <= res_valid_d;
            z_q         <= z_d;
        end
    end

    assign bus.instr_ready  = instr_ready_c;
    assign bus.eu_op_select = op_q;
    assign bus.eu_a         = a_q;
    assign bus.eu_b         = b_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_rd       = res_rd_q;
    assign bus.z_flag       = z_q;

endmodule

// File: tb/tb_eu_sequencer.sv
// tb_eu_sequencer: directed bench for eu_sequencer with a stub combinational EU.
module tb_eu_sequencer;
    import eu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    eu_sequencer_if bus ();

    eu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub EU: arithmetic = A+B, logic = A&B, shift = B<<1
    always_comb begin
        case (bus.eu_op_select[3:2])
            CLASS_LOGIC: bus.eu_data_in = bus.eu_a & bus.eu_b;
            CLASS_SHIFT: bus.eu_data_in = {bus.eu_b[BUS_WIDTH-2:0], 1'b0};
            default:     bus.eu_data_in = bus.eu_a + bus.eu_b;
        endcase
        bus.eu_zero = (bus.eu_data_in == 16'h0000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        @(posedge clk); #1;
        bus.ld_en   = 1'b0;
    endtask

    task automatic issue_instr(input logic [3:0] op, input logic [2:0] rd,
                               input logic [2:0] ra, input logic [2:0] rb,
                               input logic [2:0] rsvd, output bit acc);
        int n;
        bus.instr       = {op, rd, ra, rb, rsvd};
        bus.instr_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            #1;
            acc = bus.instr_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.instr_valid = 1'b0;
    endtask

    // Edges from acceptance until res_valid is seen; -1 on timeout
    task automatic wait_res(output int lat);
        int n;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        lat = bus.res_valid ? n : -1;
    endtask

    task automatic exec_instr(input logic [3:0] op, input logic [2:0] rd,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic [2:0] rsvd,
                              output logic [15:0] data, output logic [2:0] rdo,
                              output logic z, output int lat);
        bit acc;
        issue_instr(op, rd, ra, rb, rsvd, acc);
        data = 'x;
        rdo  = 'x;
        z    = 'x;
        lat  = -1;
        if (acc) begin
            wait_res(lat);
            data = bus.res_data;
            rdo  = bus.res_rd;
            z    = bus.z_flag;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.z_flag !== 1'b0) begin errors++; $display("FAIL reset_z_flag: got %b want 0", bus.z_flag); end
        checks++; if (bus.eu_op_select !== 4'h0) begin errors++; $display("FAIL reset_eu_op: got %h want 0", bus.eu_op_select); end
        checks++; if (bus.eu_a !== 16'h0 || bus.eu_b !== 16'h0) begin errors++; $display("FAIL reset_eu_ab: got %h/%h want 0/0", bus.eu_a, bus.eu_b); end
        checks++; if (bus.res_data !== 16'h0 || bus.res_rd !== 3'd0) begin errors++; $display("FAIL reset_res: got %h/%0d want 0/0", bus.res_data, bus.res_rd); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready: got %b want 1", bus.instr_ready); end
    endtask

    task automatic test_reset_mid_resp();
        logic [15:0] d; logic [2:0] r; logic z; int lat; bit acc;
        exec_instr(4'h0, 3'd2, 3'd0, 3'd0, 3'd0, d, r, z, lat);
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL rstresp_pre_z: got %b want 1", z); end
        do_load(3'd1, 16'h0005);
        bus.res_ready = 1'b0;
        issue_instr(4'h0, 3'd3, 3'd1, 3'd1, 3'd0, acc);
        wait_res(lat);
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h000A) begin errors++; $display("FAIL rstresp_pre_res: got v=%b d=%h want v=1 d=000a", bus.res_valid, bus.res_data); end
        rst = 1'b1;
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstresp_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.z_flag !== 1'b0) begin errors++; $display("FAIL rstresp_z_flag: got %b want 0", bus.z_flag); end
        checks++; if (bus.res_data !== 16'h0 || bus.eu_a !== 16'h0) begin errors++; $display("FAIL rstresp_regs_out: got d=%h a=%h want 0/0", bus.res_data, bus.eu_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rstresp_instr_ready: got %b want 1", bus.instr_ready); end
        exec_instr(4'h0, 3'd5, 3'd1, 3'd3, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rstresp_regs_cleared: got %h want 0000", d); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL rstresp_post_z: got %b want 1", z); end
    endtask

    task automatic test_basic_add();
        logic [15:0] d; logic [2:0] r; logic z; int lat;
        do_load(3'd0, 16'h0000);
        do_load(3'd1, 16'h0003);
        do_load(3'd2, 16'h0004);
        exec_instr(4'h0, 3'd3, 3'd1, 3'd2, 3'd0, d, r, z, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        checks++; if (d !== 16'h0007) begin errors++; $display("FAIL add_data: got %h want 0007", d); end
        checks++; if (r !== 3'd3) begin errors++; $display("FAIL add_rd: got %0d want 3", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL add_z: got %b want 0", z); end
        checks++; if (bus.eu_a !== 16'h0003 || bus.eu_b !== 16'h0004) begin errors++; $display("FAIL add_eu_hold: got %h/%h want 0003/0004", bus.eu_a, bus.eu_b); end
        exec_instr(4'h0, 3'd5, 3'd3, 3'd0, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0007) begin errors++; $display("FAIL add_r3_written: got %h want 0007", d); end
    endtask

    task automatic test_zero_sticky();
        logic [15:0] d; logic [2:0] r; logic z; int lat;
        do_load(3'd1, 16'hFFFF);
        do_load(3'd2, 16'h0001);
        exec_instr(4'h0, 3'd4, 3'd1, 3'd2, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL zero_add: got d=%h z=%b want 0000/1", d, z); end
        exec_instr(4'h8, 3'd5, 3'd1, 3'd1, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'hFFFF || r !== 3'd5) begin errors++; $display("FAIL zero_logic_res: got d=%h rd=%0d want ffff/5", d, r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL zero_logic_sticky: got %b want 1", z); end
        exec_instr(4'hC, 3'd6, 3'd2, 3'd2, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0002 || z !== 1'b1) begin errors++; $display("FAIL zero_shift_sticky: got d=%h z=%b want 0002/1", d, z); end
        exec_instr(4'h4, 3'd6, 3'd2, 3'd2, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0002 || z !== 1'b0) begin errors++; $display("FAIL zero_arith_clear: got d=%h z=%b want 0002/0", d, z); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d; logic [2:0] r; logic z; int lat; bit acc;
        do_load(3'd1, 16'h0010);
        do_load(3'd2, 16'h0020);
        bus.res_ready = 1'b0;
        issue_instr(4'h0, 3'd7, 3'd1, 3'd2, 3'd0, acc);
        wait_res(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL bp_latency: got %0d want 1", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0030 || bus.res_rd !== 3'd7 || bus.instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h rd=%0d rdy=%b want 1/0030/7/0", i, bus.res_valid, bus.res_data, bus.res_rd, bus.instr_ready);
            end
            if (i == 1) begin
                bus.ld_en = 1'b1; bus.ld_addr = 3'd1; bus.ld_data = 16'hAAAA;
            end else begin
                bus.ld_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.ld_en = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", bus.res_valid, bus.instr_ready); end
        exec_instr(4'h0, 3'd5, 3'd1, 3'd0, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0010) begin errors++; $display("FAIL bp_load_dropped: got %h want 0010", d); end
    endtask

    task automatic test_collision();
        int lat;
        bus.ld_en       = 1'b1;
        bus.ld_addr     = 3'd6;
        bus.ld_data     = 16'h0010;
        bus.instr       = {4'hC, 3'd7, 3'd0, 3'd6, 3'd0};
        bus.instr_valid = 1'b1;
        #1;
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL coll_blocked: got %b want 0", bus.instr_ready); end
        @(posedge clk); #1;
        bus.ld_en = 1'b0;
        #1;
        checks++; if (bus.instr_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL coll_pending: got rdy=%b v=%b want 1/0", bus.instr_ready, bus.res_valid); end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        checks++; if (bus.eu_op_select !== 4'hC || bus.eu_b !== 16'h0010) begin errors++; $display("FAIL coll_eu_in: got op=%h b=%h want c/0010", bus.eu_op_select, bus.eu_b); end
        wait_res(lat);
        checks++; if (lat !== 1 || bus.res_data !== 16'h0020 || bus.res_rd !== 3'd7) begin errors++; $display("FAIL coll_result: got lat=%0d d=%h rd=%0d want 1/0020/7", lat, bus.res_data, bus.res_rd); end
        @(posedge clk); #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL coll_consumed: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_self_overwrite();
        logic [15:0] d; logic [2:0] r; logic z; int lat;
        do_load(3'd2, 16'h0008);
        exec_instr(4'h0, 3'd2, 3'd2, 3'd2, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0010 || bus.eu_a !== 16'h0008) begin errors++; $display("FAIL self_first: got d=%h a=%h want 0010/0008", d, bus.eu_a); end
        exec_instr(4'h0, 3'd2, 3'd2, 3'd2, 3'd0, d, r, z, lat);
        checks++; if (d !== 16'h0020 || bus.eu_a !== 16'h0010) begin errors++; $display("FAIL self_second: got d=%h a=%h want 0020/0010", d, bus.eu_a); end
    endtask

    task automatic test_reserved_bits();
        logic [15:0] d; logic [2:0] r; logic z; int lat;
        do_load(3'd1, 16'h0001);
        do_load(3'd2, 16'h0002);
        exec_instr(4'h0, 3'd3, 3'd1, 3'd2, 3'd7, d, r, z, lat);
        checks++; if (d !== 16'h0003 || r !== 3'd3) begin errors++; $display("FAIL rsvd_ignored: got d=%h rd=%0d want 0003/3", d, r); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_en       = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        bus.res_ready   = 1'b1;
        test_reset();
        test_reset_mid_resp();
        test_basic_add();
        test_zero_sticky();
        test_backpressure();
        test_collision();
        test_self_overwrite();
        test_reserved_bits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
